// File: rtl/mux_logic_unit.sv
// mux_logic_unit: pipelined WIDTH-bit two-operand logic unit. Every result bit
// is a 4:1 mux over a per-op truth table indexed by {a[i], b[i]}. Results pass
// through a two-entry output buffer whose head register drives y/eq/op_out, so
// there is no combinational path from the operands to the outputs.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready depends only on buffer occupancy (never on
// out_ready); out_valid means the head register holds an unconsumed result,
// and the head stays stable while out_valid && !out_ready.
module mux_logic_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             lut_we,
    input  logic [3:0]       lut_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    output logic [2:0]       op_out,
    output logic [CNT_W-1:0] txn_count
);

    // Occupancy 0..2. Entry 0 is the head (the y/eq/op_out registers
    // themselves); entry 1 is the tail slot behind it.
    logic [1:0]       occ;
    logic [3:0]       lut;
    logic [3:0]       tt;
    logic [WIDTH-1:0] res_y;
    logic             res_eq;
    logic [WIDTH-1:0] tail_y;
    logic             tail_eq;
    logic [2:0]       tail_op;
    logic             push;
    logic             pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Truth table for the incoming op; op 7 reads the LUT register as it was
    // before this edge, so a same-edge lut_we only affects later accepts.
    always_comb begin
        tt = 4'b0000;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b1001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b1100;
            default: tt = lut;
        endcase
    end

    // Per-bit 4:1 mux plus the op-independent equality flag.
    always_comb begin
        res_y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_y[i] = tt[{a[i], b[i]}];
        end
        res_eq = ~|(a ^ b);
    end

    // Buffer, LUT and counter state; reset wins over any same-edge accept or
    // LUT load and discards buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= 2'd0;
            y         <= '0;
            eq        <= 1'b0;
            op_out    <= 3'd0;
            tail_y    <= '0;
            tail_eq   <= 1'b0;
            tail_op   <= 3'd0;
            lut       <= 4'b1001;
            txn_count <= '0;
        end else begin
            if (lut_we) begin
                lut <= lut_data;
            end
            if (push) begin
                txn_count <= txn_count + CNT_W'(1);
            end
            case (occ)
                2'd0: begin
                    if (push) begin
                        y      <= res_y;
                        eq     <= res_eq;
                        op_out <= op;
                        occ    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // Head advances straight to the new result.
                        y      <= res_y;
                        eq     <= res_eq;
                        op_out <= op;
                    end else if (push) begin
                        tail_y  <= res_y;
                        tail_eq <= res_eq;
                        tail_op <= op;
                        occ     <= 2'd2;
                    end else if (pop) begin
                        // Empty: head registers keep their last values.
                        occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        y      <= tail_y;
                        eq     <= tail_eq;
                        op_out <= tail_op;
                        occ    <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_logic_unit.sv
// Bench for mux_logic_unit: directed scenarios plus a randomized run checked
// against a queue-based reference model built from the operation rules.
module tb_mux_logic_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT (defaults: WIDTH=8, CNT_W=16)
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [2:0]  op = '0;
  logic        lut_we = 1'b0;
  logic [3:0]  lut_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  y;
  logic        eq;
  logic [2:0]  op_out;
  logic [15:0] txn_count;

  // counter-wrap DUT (CNT_W=4)
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [7:0]  w_a = '0;
  logic [7:0]  w_b = '0;
  logic [2:0]  w_op = '0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [7:0]  w_y;
  logic        w_eq;
  logic [2:0]  w_op_out;
  logic [3:0]  w_txn;

  int vectors = 0;
  int miscompares = 0;

  mux_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .lut_we(lut_we), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .eq(eq),
    .op_out(op_out), .txn_count(txn_count)
  );

  mux_logic_unit #(.WIDTH(8), .CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .lut_we(1'b0), .lut_data(4'b0000),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .y(w_y), .eq(w_eq),
    .op_out(w_op_out), .txn_count(w_txn)
  );

  // ---------------- reference model ----------------
  // Scoreboard entries are {y, eq, op}.
  logic [11:0] exp_q[$];
  logic [3:0]  m_lut;
  logic [15:0] m_cnt;
  logic [11:0] m_head;

  function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x,
                                       input logic [7:0] z, input logic [3:0] l);
    logic [7:0] r;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x ^ z);
      3'd4: r = ~(x & z);
      3'd5: r = ~(x | z);
      3'd6: r = x;
      default: begin
        r = '0;
        for (int i = 0; i < 8; i++) begin
          r[i] = l[2 * x[i] + z[i]];
        end
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_lut  = 4'b1001;
    m_cnt  = '0;
    m_head = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = 1'b0;
    lut_we = 1'b0;
    out_ready = 1'b0;
    w_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      miscompares++;
    end
    vectors++;
    if (y !== 8'h00 || eq !== 1'b0 || op_out !== 3'd0 || txn_count !== 16'd0) begin
      $display("FAIL reset_outputs: y=%h eq=%b op_out=%0d cnt=%0d, want 0/0/0/0", y, eq, op_out, txn_count);
      miscompares++;
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y[7];
    exp_y = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'hF0};
    do_reset();
    a = 8'hF0; b = 8'hCC; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      op = 3'(k);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || y !== exp_y[k] || eq !== 1'b0 || op_out !== 3'(k)) begin
        $display("FAIL sweep_op%0d: valid=%b y=%h eq=%b op_out=%0d, want 1/%h/0/%0d",
                 k, out_valid, y, eq, op_out, exp_y[k], k);
        miscompares++;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (txn_count !== 16'd7) begin
      $display("FAIL sweep_count: got %0d want 7", txn_count);
      miscompares++;
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || y !== 8'hF0) begin
      $display("FAIL sweep_drain: valid=%b y=%h, want 0/f0", out_valid, y);
      miscompares++;
    end
  endtask

  task automatic test_eq();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'h5A; b = 8'h5A; op = 3'd2;
    tick();
    vectors++;
    if (y !== 8'h00 || eq !== 1'b1 || op_out !== 3'd2) begin
      $display("FAIL eq_equal: y=%h eq=%b op=%0d, want 00/1/2", y, eq, op_out);
      miscompares++;
    end
    b = 8'h5B; op = 3'd3;
    tick();
    vectors++;
    if (y !== 8'hFE || eq !== 1'b0 || op_out !== 3'd3) begin
      $display("FAIL eq_differ: y=%h eq=%b op=%0d, want fe/0/3", y, eq, op_out);
      miscompares++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_lut();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'hF0; b = 8'hCC; op = 3'd7;
    tick();
    vectors++;
    if (y !== 8'hC3) begin
      $display("FAIL lut_default: got %h want c3", y);
      miscompares++;
    end
    lut_we = 1'b1; lut_data = 4'b0100;
    tick();
    lut_we = 1'b0;
    vectors++;
    if (y !== 8'hC3) begin
      $display("FAIL lut_same_edge: got %h want c3", y);
      miscompares++;
    end
    tick();
    vectors++;
    if (y !== 8'h30) begin
      $display("FAIL lut_new: got %h want 30", y);
      miscompares++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'hF0; b = 8'hCC; op = 3'd0;
    tick();
    op = 3'd1;
    tick();
    vectors++;
    if (in_ready !== 1'b0 || y !== 8'hC0 || out_valid !== 1'b1) begin
      $display("FAIL full_after_two: in_ready=%b y=%h valid=%b, want 0/c0/1", in_ready, y, out_valid);
      miscompares++;
    end
    op = 3'd2;
    tick();
    vectors++;
    if (y !== 8'hC0 || txn_count !== 16'd2 || in_ready !== 1'b0) begin
      $display("FAIL full_hold: y=%h cnt=%0d in_ready=%b, want c0/2/0", y, txn_count, in_ready);
      miscompares++;
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (y !== 8'hFC || in_ready !== 1'b1 || txn_count !== 16'd2) begin
      $display("FAIL first_pop: y=%h in_ready=%b cnt=%0d, want fc/1/2", y, in_ready, txn_count);
      miscompares++;
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (y !== 8'h3C || op_out !== 3'd2 || txn_count !== 16'd3 || out_valid !== 1'b1) begin
      $display("FAIL third_accept: y=%h op=%0d cnt=%0d valid=%b, want 3c/2/3/1", y, op_out, txn_count, out_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || y !== 8'h3C) begin
      $display("FAIL drain_hold: valid=%b y=%h, want 0/3c", out_valid, y);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lut_we = 1'b1; lut_data = 4'b0000;
    tick();
    lut_we = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h12; b = 8'h34; op = 3'd1;
    tick();
    tick();
    lut_we = 1'b1; lut_data = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0; lut_we = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00 || txn_count !== 16'd0) begin
      $display("FAIL reset_mid: valid=%b in_ready=%b y=%h cnt=%0d, want 0/1/00/0",
               out_valid, in_ready, y, txn_count);
      miscompares++;
    end
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'hF0; b = 8'hCC; op = 3'd7;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (y !== 8'hC3) begin
      $display("FAIL reset_mid_lut: got %h want c3", y);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_random();
    logic        exp_ready;
    logic        acc;
    logic        pp;
    logic [7:0]  ry;
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      lut_we    = ($urandom_range(0, 7) == 0);
      lut_data  = 4'($urandom_range(0, 15));
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 4) == 0) ? a : 8'($urandom_range(0, 255));
      op = 3'($urandom_range(0, 7));
      exp_ready = (exp_q.size() < 2);
      vectors++;
      if (in_ready !== exp_ready || out_valid !== (exp_q.size() > 0)) begin
        $display("FAIL rand_hs[%0d]: in_ready=%b out_valid=%b, want %b/%b",
                 n, in_ready, out_valid, exp_ready, exp_q.size() > 0);
        miscompares++;
      end
      acc = in_valid && exp_ready;
      pp  = out_ready && (exp_q.size() > 0);
      ry  = ref_y(op, a, b, m_lut);
      tick();
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({ry, (a == b), op});
        m_cnt++;
      end
      if (lut_we) m_lut = lut_data;
      if (exp_q.size() > 0) m_head = exp_q[0];
      vectors++;
      if ({y, eq, op_out} !== m_head || txn_count !== m_cnt) begin
        $display("FAIL rand_out[%0d]: y=%h eq=%b op=%0d cnt=%0d, want %h/%b/%0d/%0d",
                 n, y, eq, op_out, txn_count, m_head[11:4], m_head[3], m_head[2:0], m_cnt);
        miscompares++;
      end
    end
    drive_idle();
  endtask

  task automatic test_count_wrap();
    do_reset();
    w_in_valid = 1'b1; w_out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      w_a = 8'($urandom_range(0, 255));
      w_b = 8'($urandom_range(0, 255));
      w_op = 3'($urandom_range(0, 6));
      tick();
      if (i == 15 || i == 16 || i == 17) begin
        vectors++;
        if (w_txn !== 4'(i)) begin
          $display("FAIL wrap_after_%0d: got %0d want %0d", i, w_txn, 4'(i));
          miscompares++;
        end
      end
    end
    w_in_valid = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sweep();
    test_eq();
    test_lut();
    test_back_to_back_full();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
